uart_time_reporter: RTL
=======================

Name: uart_time_reporter

Overview:
- Upstream feeder for the 8N1 UART transmitter.
- On a report request it snapshots the current clock time (hours/minutes/seconds, binary) and emits the ASCII string "HH:MM:SS" (optionally followed by CR LF) one byte at a time over a valid/ready handshake.
- Its tx_data/tx_valid/tx_ready connect directly to the transmitter's data input port.
- It has one request of buffering, so a per-second report tick never stalls the clock core.

Parameters:
- SEND_CRLF, 1, 1 = append 8'h0D 8'h0A (message length 10); 0 = message length 8
- OVERRUN_W, 8, width of the saturating dropped-request counter

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- report_req  in  1  single-cycle request to send the current time
- hours  in  5  binary hours, sampled only when a request is accepted
- minutes  in  6  binary minutes
- seconds  in  6  binary seconds
- tx_data  out  8  ASCII byte to the transmitter
- tx_valid  out  1  tx_data is valid
- tx_ready  in  1  transmitter can accept a byte
- busy  out  1  message in progress or pending
- overrun_cnt  out  OVERRUN_W  number of dropped requests, saturating

Behaviour:
- Reset (reset_n=0 at an edge): tx_valid=0, tx_data=8'h00, busy=0, overrun_cnt=0, pending cleared, state=IDLE. Applies mid-message: the message is aborted with no further bytes, and the transmitter finishes only the byte it already holds.
- Transfer occurs on an edge where tx_valid=1 and tx_ready=1. While tx_valid=1 and not yet accepted, tx_data must stay stable.
- Digit conversion per field: tens = v/10, ones = v%10, each char = 8'h30 + digit. Values out of clock range are sent verbatim (hours 31 -> "31", minutes 63 -> "63"). Never more than two digits.
- Byte order: H10 H1 ':' M10 M1 ':' S10 S1 [CR LF].
- States:
  - IDLE: tx_valid=0. If report_req=1 at edge N: snapshot h/m/s into the active registers, index=0, go to SEND. tx_valid=1 and tx_data=H10 from cycle N+1.
  - SEND: on each transfer, index++ and tx_data updates to the next char in the following cycle, with tx_valid held 1 (back-to-back, no bubble).
  - Transfer of the last byte (index=MSG_LEN-1):
    - pending set: active <= pending snapshot, pending cleared, index=0, stay in SEND. The next message's first byte is valid the next cycle.
    - else if report_req=1 on that same edge: snapshot the live inputs and continue in the same way.
    - else: tx_valid=0, go to IDLE.
- report_req while in SEND (excluding the last-byte edge handled above):
  - pending clear: snapshot the inputs into the pending registers and set pending.
  - pending set: request dropped, overrun_cnt++, saturating at all ones.
- Last-byte edge with pending set and report_req=1: the pending message is sent next, and the new request becomes the new pending entry.
- busy = (state==SEND) | pending.
- Latency: request to first tx_valid = 1 cycle. The block never deasserts tx_valid before a transfer.

Decomposition:
- Package uart_pkg: ASCII_0=8'h30, ASCII_COLON=8'h3A, ASCII_CR=8'h0D, ASCII_LF=8'h0A, and a MSG_LEN function of SEND_CRLF.
- Sub-module bin2ascii_2digit: 6-bit binary in, two 8-bit ASCII chars out, combinational, instantiated three times on the active snapshot.

Test Plan:
- 12:34:56, single request, tx_ready tied 1 -> bytes 31 32 3A 33 34 3A 35 36 0D 0A on 10 consecutive cycles starting 1 cycle after the request; then tx_valid=0, busy=0.
- Same time, tx_ready modelled as the real transmitter (ready only in idle, ~10 baud ticks per byte) -> identical byte sequence; tx_data stable whenever tx_valid=1 and tx_ready=0.
- Request 00:00:09, then change inputs to 23:59:59 and request again mid-message -> first message "00:00:09\r\n", immediately followed by "23:59:59\r\n" with no idle cycle. overrun_cnt=0.
- Three requests during one message -> two messages sent, overrun_cnt=1. 300 dropped requests with OVERRUN_W=8 -> overrun_cnt saturates at 255.
- reset_n=0 after the 4th byte of a message with pending set -> next cycle tx_valid=0, busy=0, overrun_cnt=0; a new request afterwards sends a complete, fresh message.
- SEND_CRLF=0, inputs 31/63/63 -> "31:63:63", 8 bytes only. Request asserted on the last-byte edge -> second message starts the next cycle.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared ASCII constants, FSM state, time snapshot type and message length
package uart_pkg;
    localparam logic [7:0] ASCII_0     = 8'h30;
    localparam logic [7:0] ASCII_COLON = 8'h3A;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;

    typedef enum logic {IDLE, SEND} state_t;

    typedef struct packed {
        logic [4:0] h;
        logic [5:0] m;
        logic [5:0] s;
    } hms_t;

    function automatic logic [3:0] msg_len(input bit send_crlf);
        return send_crlf ? 4'd10 : 4'd8;
    endfunction
endpackage

// File: rtl/bin2ascii_2digit.sv
// bin2ascii_2digit: 6-bit binary to two ASCII decimal digits (combinational)
//   value : binary input 0..63
//   tens  : ASCII of value/10
//   ones  : ASCII of value%10
module bin2ascii_2digit
    import uart_pkg::*;
(
    input  logic [5:0] value,
    output logic [7:0] tens,
    output logic [7:0] ones
);
    logic [5:0] t;
    always_comb begin
        t    = value / 6'd10;
        tens = ASCII_0 + {2'b00, t};
        ones = ASCII_0 + {2'b00, value - t * 6'd10};
    end
endmodule

// File: rtl/uart_time_reporter.sv
// uart_time_reporter: snapshots h/m/s on request and streams "HH:MM:SS[\r\n]" over valid/ready
//   clk, reset_n          : clock, synchronous active-low reset
//   report_req            : single-cycle report request
//   hours/minutes/seconds : binary time, sampled when a request is accepted
//   tx_data/tx_valid/tx_ready : byte stream to the UART transmitter
//   busy                  : message in progress or one request pending
//   overrun_cnt           : saturating count of dropped requests
module uart_time_reporter
    import uart_pkg::*;
#(
    parameter bit SEND_CRLF = 1'b1,
    parameter int OVERRUN_W = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 report_req,
    input  logic [4:0]           hours,
    input  logic [5:0]           minutes,
    input  logic [5:0]           seconds,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic                 busy,
    output logic [OVERRUN_W-1:0] overrun_cnt
);
    localparam logic [3:0] LAST = msg_len(SEND_CRLF) - 4'd1;

    state_t               state, state_n;
    logic [3:0]           idx, idx_n;
    hms_t                 act, act_n, pend, pend_n, live;
    logic                 pend_v, pend_v_n;
    logic [OVERRUN_W-1:0] ovr_n;
    logic                 xfer;
    logic [7:0]           h10, h1, m10, m1, s10, s1;

    bin2ascii_2digit u_h (.value({1'b0, act.h}), .tens(h10), .ones(h1));
    bin2ascii_2digit u_m (.value(act.m),         .tens(m10), .ones(m1));
    bin2ascii_2digit u_s (.value(act.s),         .tens(s10), .ones(s1));

    assign live     = '{h: hours, m: minutes, s: seconds};
    assign tx_valid = state == SEND;
    assign xfer     = tx_valid && tx_ready;
    assign busy     = tx_valid || pend_v;

    // tx_data depends only on registered state, so it holds while the transmitter stalls
    always_comb begin
        tx_data = 8'h00;
        if (state == SEND) begin
            case (idx)
                4'd0:    tx_data = h10;
                4'd1:    tx_data = h1;
                4'd2:    tx_data = ASCII_COLON;
                4'd3:    tx_data = m10;
                4'd4:    tx_data = m1;
                4'd5:    tx_data = ASCII_COLON;
                4'd6:    tx_data = s10;
                4'd7:    tx_data = s1;
                4'd8:    tx_data = ASCII_CR;
                4'd9:    tx_data = ASCII_LF;
                default: tx_data = 8'h00;
            endcase
        end
    end

    always_comb begin
        state_n  = state;
        idx_n    = idx;
        act_n    = act;
        pend_n   = pend;
        pend_v_n = pend_v;
        ovr_n    = overrun_cnt;
        if (state == IDLE) begin
            if (report_req) begin
                state_n = SEND;
                idx_n   = 4'd0;
                act_n   = live;
            end
        end else if (xfer && idx == LAST) begin
            // last byte: chain straight into pending or a same-edge request, no idle gap
            if (pend_v) begin
                act_n    = pend;
                idx_n    = 4'd0;
                pend_v_n = report_req;
                if (report_req) pend_n = live;
            end else if (report_req) begin
                act_n = live;
                idx_n = 4'd0;
            end else begin
                state_n = IDLE;
            end
        end else begin
            if (xfer) idx_n = idx + 4'd1;
            if (report_req) begin
                if (!pend_v) begin
                    pend_n   = live;
                    pend_v_n = 1'b1;
                end else if (overrun_cnt != '1) begin
                    ovr_n = overrun_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            idx         <= 4'd0;
            act         <= '0;
            pend        <= '0;
            pend_v      <= 1'b0;
            overrun_cnt <= '0;
        end else begin
            state       <= state_n;
            idx         <= idx_n;
            act         <= act_n;
            pend        <= pend_n;
            pend_v      <= pend_v_n;
            overrun_cnt <= ovr_n;
        end
    end
endmodule
